// File: rtl/booth_pkg.sv
// Shared definitions for the sequential Booth multiplier controller:
// register-control mode codes, FSM state encoding and counter width.
package booth_pkg;

    typedef enum logic [1:0] {
        MODE_LOAD  = 2'b00,
        MODE_RESET = 2'b01,
        MODE_SHIFT = 2'b10,
        MODE_HOLD  = 2'b11
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_EXAM  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int CNT_W = 4;

endpackage

// File: rtl/booth_iter_cnt.sv
// Booth iteration counter: cleared on LOAD, stepped once per SHIFT,
// flags the final iteration and never advances past N-1.
module booth_iter_cnt
    import booth_pkg::*;
#(
    parameter int N = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    assign last = (count == CNT_W'(N - 1));

    // Saturating at N-1 means the only path back to zero is an explicit clear.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && !last) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/booth_seq_ctrl.sv
// Control FSM for a sequential radix-2 Booth multiplier: sequences
// load, N examine/shift iterations and a one-cycle done pulse.
module booth_seq_ctrl
    import booth_pkg::*;
#(
    parameter int N = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       q0,
    input  logic       qm1,
    output logic [1:0] q_mode,
    output logic [1:0] a_mode,
    output logic       alu_sub,
    output logic       busy,
    output logic       done,
    output state_t     state
);

    // Handshake: start is a level request taken only when the FSM is in
    // IDLE; done pulses for exactly one cycle when the product is valid,
    // and busy covers LOAD through the last SHIFT. Requests seen while
    // busy or in DONE are dropped, never queued.

    state_t           state_q, state_d;
    mode_t            q_mode_s, a_mode_s;
    logic             cnt_clear, cnt_inc, cnt_last;
    logic [CNT_W-1:0] cnt;

    booth_iter_cnt #(.N(N)) u_iter_cnt (
        .clock (clock),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .count (cnt),
        .last  (cnt_last)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = ST_IDLE;
        q_mode_s  = MODE_HOLD;
        a_mode_s  = MODE_HOLD;
        alu_sub   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = start ? ST_LOAD : ST_IDLE;
            end
            ST_LOAD: begin
                q_mode_s  = MODE_LOAD;
                a_mode_s  = MODE_RESET;
                busy      = 1'b1;
                cnt_clear = 1'b1;
                state_d   = ST_EXAM;
            end
            ST_EXAM: begin
                busy    = 1'b1;
                state_d = ST_SHIFT;
                // 01 adds the multiplicand, 10 subtracts it; 00/11 leave A alone.
                if (q0 != qm1) begin
                    a_mode_s = MODE_LOAD;
                    alu_sub  = q0;
                end
            end
            ST_SHIFT: begin
                q_mode_s = MODE_SHIFT;
                a_mode_s = MODE_SHIFT;
                busy     = 1'b1;
                cnt_inc  = 1'b1;
                state_d  = cnt_last ? ST_DONE : ST_EXAM;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign q_mode = q_mode_s;
    assign a_mode = a_mode_s;
    assign state  = state_q;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Self-checking bench for booth_seq_ctrl: N=4 and N=2 instances share one
// stimulus stream and are compared cycle by cycle against a phase model.
module tb_booth_seq_ctrl;
    import booth_pkg::*;

    typedef logic [6:0] obs_t;  // {q_mode, a_mode, alu_sub, busy, done}

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       q0    = 1'b0;
    logic       qm1   = 1'b0;

    logic [1:0] q_mode4, a_mode4, q_mode2, a_mode2;
    logic       alu_sub4, busy4, done4, alu_sub2, busy2, done2;
    state_t     state4, state2;

    obs_t exp_q4[$];
    obs_t exp_q2[$];

    int errors = 0;
    int checks = 0;
    int t4 = -1;
    int t2 = -1;
    int done_exp4 = 0, done_exp2 = 0, done_act4 = 0, done_act2 = 0;

    always #5 clock = ~clock;

    booth_seq_ctrl #(.N(4)) dut4 (
        .clock (clock), .reset (reset), .start (start), .q0 (q0), .qm1 (qm1),
        .q_mode (q_mode4), .a_mode (a_mode4), .alu_sub (alu_sub4),
        .busy (busy4), .done (done4), .state (state4)
    );

    booth_seq_ctrl #(.N(2)) dut2 (
        .clock (clock), .reset (reset), .start (start), .q0 (q0), .qm1 (qm1),
        .q_mode (q_mode2), .a_mode (a_mode2), .alu_sub (alu_sub2),
        .busy (busy2), .done (done2), .state (state2)
    );

    // Reference model: phase t counts cycles since LOAD (-1 = idle).
    // t=0 LOAD, odd t in 1..2n EXAM, even t in 2..2n SHIFT, t=2n+1 DONE.
    function automatic int next_phase(int t, int n, logic rs, logic st);
        if (rs) return -1;
        if (t < 0) return st ? 0 : -1;
        if (t == 2 * n + 1) return -1;
        return t + 1;
    endfunction

    function automatic obs_t expect_out(int t, int n, logic b0, logic bm1);
        logic [1:0] am;
        if (t < 0) return {2'b11, 2'b11, 1'b0, 1'b0, 1'b0};
        if (t == 0) return {2'b00, 2'b01, 1'b0, 1'b1, 1'b0};
        if (t == 2 * n + 1) return {2'b11, 2'b11, 1'b0, 1'b0, 1'b1};
        if (t % 2 == 1) begin
            am = (b0 ^ bm1) ? 2'b00 : 2'b11;
            return {2'b11, am, b0 & ~bm1, 1'b1, 1'b0};
        end
        return {2'b10, 2'b10, 1'b0, 1'b1, 1'b0};
    endfunction

    // One clock: advance model on the edge, then drive {q0,qm1} for the new
    // cycle, push expectations, and set start/reset for the following edge.
    task automatic cyc(input logic st, input logic rs, input logic [1:0] qv, input bit rnd);
        logic [1:0] q;
        @(posedge clock);
        t4 = next_phase(t4, 4, reset, start);
        t2 = next_phase(t2, 2, reset, start);
        #1;
        q = rnd ? 2'($urandom_range(0, 3)) : qv;
        {q0, qm1} = q;
        exp_q4.push_back(expect_out(t4, 4, q[1], q[0]));
        exp_q2.push_back(expect_out(t2, 2, q[1], q[0]));
        if (t4 == 9) done_exp4++;
        if (t2 == 5) done_exp2++;
        start = st;
        reset = rs;
    endtask

    always @(negedge clock) begin
        obs_t e;
        obs_t a;
        if (exp_q4.size() > 0) begin
            e = exp_q4.pop_front();
            a = {q_mode4, a_mode4, alu_sub4, busy4, done4};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL n4_outputs at %0t: got %b expected %b (t=%0d)", $time, a, e, t4);
            end
            if (done4) done_act4++;
        end
        if (exp_q2.size() > 0) begin
            e = exp_q2.pop_front();
            a = {q_mode2, a_mode2, alu_sub2, busy2, done2};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL n2_outputs at %0t: got %b expected %b (t=%0d)", $time, a, e, t2);
            end
            if (done2) done_act2++;
        end
    end

    initial begin
        logic [1:0] pat[10];
        pat = '{2'b00, 2'b10, 2'b00, 2'b11, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};

        // Reset for two edges, then idle.
        cyc(1'b0, 1'b1, 2'b00, 1'b1);
        repeat (5) cyc(1'b0, 1'b0, 2'b00, 1'b1);

        // Directed operation: EXAM patterns 10, 11, 01, 00.
        cyc(1'b1, 1'b0, 2'b00, 1'b1);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, pat[i], (i % 2) == 0);
        repeat (3) cyc(1'b0, 1'b0, 2'b00, 1'b1);

        // Extra start pulses mid-operation are ignored.
        cyc(1'b1, 1'b0, 2'b00, 1'b1);
        for (int i = 1; i <= 12; i++) cyc(i == 3 || i == 6, 1'b0, 2'b00, 1'b1);

        // Start held high: back-to-back operations.
        repeat (30) cyc(1'b1, 1'b0, 2'b00, 1'b1);
        repeat (12) cyc(1'b0, 1'b0, 2'b00, 1'b1);

        // Reset during the second SHIFT aborts, then a clean operation.
        cyc(1'b1, 1'b0, 2'b00, 1'b1);
        for (int k = 0; k < 6; k++) cyc(1'b0, k == 4, 2'b00, 1'b1);
        cyc(1'b1, 1'b0, 2'b00, 1'b1);
        repeat (13) cyc(1'b0, 1'b0, 2'b00, 1'b1);

        // Randomized traffic with occasional resets.
        repeat (400) cyc($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0, 2'b00, 1'b1);
        cyc(1'b0, 1'b0, 2'b00, 1'b1);
        @(negedge clock);
        #1;

        checks++;
        if (exp_q4.size() != 0 || exp_q2.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: left n4=%0d n2=%0d required 0", exp_q4.size(), exp_q2.size());
        end
        checks++;
        if (done_act4 != done_exp4) begin
            errors++;
            $display("FAIL n4_done_count: got %0d expected %0d", done_act4, done_exp4);
        end
        checks++;
        if (done_act2 != done_exp2) begin
            errors++;
            $display("FAIL n2_done_count: got %0d expected %0d", done_act2, done_exp2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
